imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 141 ++++++++++++++
 tb/tb_imm_encoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: range-checks a LOAD/STORE/BRANCH request, packs it into a
// 32-bit instruction word and hands it out through a one-entry output
// register, tagging each word with a running byte address.
module imm_encoder #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_fmt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err_pulse,
   output logic              err_flag,
   output logic [15:0]       count
);

   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);
   localparam logic [6:0]        OP_LOAD   = 7'b0000011;
   localparam logic [6:0]        OP_STORE  = 7'b0100011;
   localparam logic [6:0]        OP_BRANCH = 7'b1100011;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [ADDR_W-1:0]   wr_ptr_q;
   logic [ADDR_W-1:0]   wr_ptr_d;
   logic [ADDR_W-1:0]   out_addr_d;
   logic [31:0]         out_instr_d;
   logic                err_pulse_d;
   logic                err_flag_d;
   logic [15:0]         count_d;
   logic [31:0]         enc_c;
   logic                imm_ok_c;
   logic                accept_c;
   logic                drain_c;
   logic signed [31:0]  simm_c;

   assign in_ready  = (state_q == EMPTY) | out_ready;
   assign out_valid = (state_q == FULL);
   assign accept_c  = in_valid & in_ready & ~clr;
   assign drain_c   = out_valid & out_ready;
   assign simm_c    = $signed(in_imm);

   // Immediate range check per format; the reserved format never passes
   always_comb begin
      imm_ok_c = 1'b0;
      case (in_fmt)
         2'b00, 2'b01: imm_ok_c = (simm_c >= -32'sd2048) && (simm_c <= 32'sd2047);
         2'b10:        imm_ok_c = (simm_c >= -32'sd4096) && (simm_c <= 32'sd4094) && !in_imm[0];
         default:      imm_ok_c = 1'b0;
      endcase
   end

   // Instruction packing; unused register fields simply do not appear
   always_comb begin
      enc_c = '0;
      case (in_fmt)
         2'b00:   enc_c = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
         2'b01:   enc_c = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
         default: enc_c = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], OP_BRANCH};
      endcase
   end

   // Next-state and next-register values; clr overrides every handshake
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      out_instr_d = out_instr;
      out_addr_d  = out_addr;
      err_pulse_d = 1'b0;
      err_flag_d  = err_flag;
      count_d     = count;
      if (clr) begin
         state_d     = EMPTY;
         wr_ptr_d    = BASE;
         out_instr_d = '0;
         out_addr_d  = '0;
         err_flag_d  = 1'b0;
         count_d     = '0;
      end else begin
         if (drain_c) begin
            state_d = EMPTY;
            if (count != 16'hFFFF) count_d = count + 16'd1;
         end
         if (accept_c) begin
            if (imm_ok_c) begin
               state_d     = FULL;
               out_instr_d = enc_c;
               out_addr_d  = wr_ptr_q;
               wr_ptr_d    = wr_ptr_q + ADDR_STEP;
            end else begin
               err_pulse_d = 1'b1;
               err_flag_d  = 1'b1;
            end
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= BASE;
         out_instr <= '0;
         out_addr  <= '0;
         err_pulse <= 1'b0;
         err_flag  <= 1'b0;
         count     <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         out_instr <= out_instr_d;
         out_addr  <= out_addr_d;
         err_pulse <= err_pulse_d;
         err_flag  <= err_flag_d;
         count     <= count_d;
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed scenarios followed by random
// traffic, compared against a transaction-level reference model.
module tb_imm_encoder;

   logic        clk = 1'b0;
   logic        rst_n, clr, in_valid, out_ready;
   logic [1:0]  in_fmt;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic [31:0] in_imm;

   logic        in_ready, out_valid, err_pulse, err_flag;
   logic [31:0] out_instr;
   logic [9:0]  out_addr;
   logic [15:0] count;

   logic        s_in_ready, s_out_valid, s_err_pulse, s_err_flag;
   logic [31:0] s_out_instr;
   logic [3:0]  s_out_addr;
   logic [15:0] s_count;

   int errors = 0;
   int checks = 0;

   // Reference model state
   bit          m_held;
   logic [31:0] m_instr;
   int unsigned m_addr, m_addr_s, m_ptr, m_ptr_s, m_cnt;
   bit          m_errf, m_ep;

   always #5 clk = ~clk;

   imm_encoder u_dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_imm(in_imm), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
      .err_pulse(err_pulse), .err_flag(err_flag), .count(count)
   );

   imm_encoder #(.ADDR_W(4)) u_small (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_imm(in_imm), .out_valid(s_out_valid),
      .out_ready(out_ready), .out_instr(s_out_instr), .out_addr(s_out_addr),
      .err_pulse(s_err_pulse), .err_flag(s_err_flag), .count(s_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Instruction word built from field values with shifts and masks
   function automatic logic [31:0] ref_enc(input logic [1:0] f, input logic [4:0] rd, rs1, rs2,
                                           input logic [2:0] f3, input logic [31:0] imm);
      logic [31:0] regs;
      regs = (32'(rs1) << 15) | (32'(f3) << 12);
      case (f)
         2'd0:    return ((imm & 32'hFFF) << 20) | regs | (32'(rd) << 7) | 32'd3;
         2'd1:    return (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs
                         | ((imm & 32'h1F) << 7) | 32'd35;
         default: return (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                         | (32'(rs2) << 20) | regs | (((imm >> 1) & 32'hF) << 8)
                         | (((imm >> 11) & 32'd1) << 7) | 32'd99;
      endcase
   endfunction

   function automatic bit ref_ok(input logic [1:0] f, input logic [31:0] imm);
      int s;
      s = imm;
      case (f)
         2'd0, 2'd1: return (s >= -2048) && (s <= 2047);
         2'd2:       return (s >= -4096) && (s <= 4094) && (imm[0] == 1'b0);
         default:    return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_held = 0; m_instr = '0; m_addr = 0; m_addr_s = 0;
      m_ptr = 0; m_ptr_s = 0; m_cnt = 0; m_errf = 0; m_ep = 0;
   endtask

   // One clock edge of the transaction-level behaviour
   task automatic model_edge();
      bit rdy, acc, drain;
      rdy = !m_held || out_ready;
      m_ep = 0;
      if (clr) begin
         m_held = 0; m_ptr = 0; m_ptr_s = 0; m_errf = 0; m_cnt = 0;
      end else begin
         acc   = in_valid && rdy;
         drain = m_held && out_ready;
         if (drain) begin
            m_held = 0;
            if (m_cnt < 65535) m_cnt++;
         end
         if (acc) begin
            if (ref_ok(in_fmt, in_imm)) begin
               m_instr  = ref_enc(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm);
               m_addr   = m_ptr;
               m_addr_s = m_ptr_s;
               m_ptr    = (m_ptr + 4) % 1024;
               m_ptr_s  = (m_ptr_s + 4) % 16;
               m_held   = 1;
            end else begin
               m_ep   = 1;
               m_errf = 1;
            end
         end
      end
   endtask

   task automatic check_outputs();
      check("out_valid", 32'(out_valid), 32'(m_held));
      check("err_pulse", 32'(err_pulse), 32'(m_ep));
      check("err_flag", 32'(err_flag), 32'(m_errf));
      check("count", 32'(count), m_cnt);
      check("s_out_valid", 32'(s_out_valid), 32'(m_held));
      if (m_held) begin
         check("out_instr", out_instr, m_instr);
         check("out_addr", 32'(out_addr), m_addr);
         check("s_out_addr", 32'(s_out_addr), m_addr_s);
      end
   endtask

   task automatic step(input logic v, input logic [1:0] f, input logic [4:0] rd, rs1, rs2,
                       input logic [2:0] f3, input logic [31:0] imm, input logic ordy,
                       input logic c);
      in_valid = v; in_fmt = f; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_imm = imm; out_ready = ordy; clr = c;
      #1;
      check("in_ready", 32'(in_ready), 32'(!m_held || ordy));
      check("s_in_ready", 32'(s_in_ready), 32'(!m_held || ordy));
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic req(input logic [1:0] f, input logic [4:0] rd, rs1, rs2,
                      input logic [2:0] f3, input logic [31:0] imm, input logic ordy);
      step(1'b1, f, rd, rs1, rs2, f3, imm, ordy, 1'b0);
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, ordy, 1'b0);
   endtask

   task automatic check_reset_values();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_addr", 32'(out_addr), 32'd0);
      check("rst_err_pulse", 32'(err_pulse), 32'd0);
      check("rst_err_flag", 32'(err_flag), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bnd [9] = '{-2048, 2047, -2049, 2048, -4096, 4094, 4095, -4097, 4093};
      logic [31:0] wrap_exp [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0};
      logic [31:0] word_a, word_b;
      int s;

      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_fmt = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_imm = '0;
      model_reset();
      #12;
      check_reset_values();
      @(negedge clk);
      rst_n = 1'b1;

      // LOAD example then a second request for the next address
      req(2'd0, 5'd5, 5'd2, 5'd0, 3'b010, 32'd8, 1'b1);
      check("ex_load_instr", out_instr, 32'h00812283);
      check("ex_load_addr", 32'(out_addr), 32'h000);
      req(2'd0, 5'd5, 5'd2, 5'd0, 3'b010, 32'd8, 1'b1);
      check("ex_load_addr2", 32'(out_addr), 32'h004);

      // STORE and BRANCH examples
      req(2'd1, 5'd0, 5'd2, 5'd6, 3'b010, -32'sd4, 1'b1);
      check("ex_store_instr", out_instr, 32'hFE612E23);
      req(2'd2, 5'd0, 5'd1, 5'd2, 3'b000, -32'sd8, 1'b1);
      check("ex_branch_instr", out_instr, 32'hFE208CE3);
      idle(1'b1);

      // Three rejected requests
      req(2'd2, 5'd0, 5'd1, 5'd2, 3'b000, 32'd3, 1'b1);
      check("rej_branch_odd", 32'(err_pulse), 32'd1);
      req(2'd0, 5'd1, 5'd1, 5'd0, 3'b000, 32'd2048, 1'b1);
      check("rej_load_range", 32'(err_pulse), 32'd1);
      req(2'd3, 5'd1, 5'd1, 5'd1, 3'b000, 32'd0, 1'b1);
      check("rej_reserved", 32'(err_pulse), 32'd1);
      check("rej_flag", 32'(err_flag), 32'd1);
      check("rej_no_word", 32'(out_valid), 32'd0);
      req(2'd0, 5'd1, 5'd1, 5'd0, 3'b000, 32'd1, 1'b1);
      check("rej_ptr_kept", 32'(out_addr), 32'h010);
      idle(1'b1);

      // Back-pressure: first word held while the second waits
      word_a = ref_enc(2'd0, 5'd3, 5'd4, 5'd0, 3'b001, 32'd100);
      word_b = ref_enc(2'd1, 5'd0, 5'd7, 5'd9, 3'b011, -32'sd100);
      req(2'd0, 5'd3, 5'd4, 5'd0, 3'b001, 32'd100, 1'b0);
      for (int i = 0; i < 3; i++) begin
         req(2'd1, 5'd0, 5'd7, 5'd9, 3'b011, -32'sd100, 1'b0);
         check("bp_hold_instr", out_instr, word_a);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      req(2'd1, 5'd0, 5'd7, 5'd9, 3'b011, -32'sd100, 1'b1);
      check("bp_no_bubble", 32'(out_valid), 32'd1);
      check("bp_second_word", out_instr, word_b);
      idle(1'b1);

      // clr while FULL, then address wrap on the narrow instance
      req(2'd0, 5'd1, 5'd1, 5'd0, 3'b000, 32'd5, 1'b0);
      step(1'b1, 2'd0, 5'd2, 5'd2, 5'd0, 3'b000, 32'd6, 1'b0, 1'b1);
      check("clr_valid", 32'(out_valid), 32'd0);
      check("clr_count", 32'(count), 32'd0);
      check("clr_flag", 32'(err_flag), 32'd0);
      for (int i = 0; i < 5; i++) begin
         req(2'd0, 5'(i), 5'd1, 5'd0, 3'b000, 32'(i), 1'b1);
         check("clr_next_addr", 32'(out_addr), 32'(i * 4));
         check("wrap_addr", 32'(s_out_addr), wrap_exp[i]);
      end

      // Reset asserted while a word is held
      req(2'd2, 5'd0, 5'd3, 5'd4, 3'b101, 32'd16, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_values();
      @(negedge clk);
      rst_n = 1'b1;
      req(2'd0, 5'd1, 5'd1, 5'd0, 3'b000, 32'd7, 1'b1);
      check("rst_next_addr", 32'(out_addr), 32'd0);
      check("rst_next_count", 32'(count), 32'd0);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         logic [31:0] imm;
         case ($urandom_range(0, 3))
            0:       s = int'($urandom_range(0, 4095)) - 2048;
            1:       s = int'($urandom_range(0, 8191)) - 4096;
            2:       s = int'($urandom);
            default: s = bnd[int'($urandom_range(0, 8))];
         endcase
         imm = 32'(s);
         step(1'($urandom_range(0, 3) != 0), 2'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 3'($urandom), imm, 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 39) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
